// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains syn_fifo one byte at a time and serializes
// each byte as a UART frame (start, data LSB first, opt. parity, stop).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_cs,
  output logic                  fifo_rd_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_WIDTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_q, par_d;
  logic                    tx_q, tx_d;
  logic                    rd_q, rd_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    baud_end;
  logic                    cnt_st;

  // Next-state, datapath and bit timing
  always_comb begin
    state_d  = state_q;
    baud_d   = '0;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    baud_end = (baud_q == BAUD_LAST);
    cnt_st   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d = fifo_data;
        par_d   = ^fifo_data;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        cnt_st = 1'b1;
        if (baud_end) begin
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_st = 1'b1;
        if (baud_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      PARITY: begin
        cnt_st = 1'b1;
        if (baud_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_st = 1'b1;
        if (baud_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Wraps at each bit boundary and clears on any state change
    if (cnt_st && !baud_end) begin
      baud_d = baud_q + BAUD_ONE;
    end
  end

  // Outputs are decoded from the next state so they register in step
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_rd_cs = rd_q;
  assign fifo_rd_en = rd_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: one instance without parity,
// one with even parity, fed from a shared FIFO model.
module tb_fifo_uart_tx;

  localparam int C = 4;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] empty;
  logic [7:0] fdata [2];
  logic [1:0] rd_cs;
  logic [1:0] rd_en;
  logic [1:0] tx;
  logic [1:0] busy;
  logic [1:0] done;

  logic [7:0] mem [64];
  int         wr_ptr = 0;
  int         checks = 0;
  int         errors = 0;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(C),
    .PARITY_EN   (0)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(empty[0]),
    .fifo_data (fdata[0]),
    .fifo_rd_cs(rd_cs[0]),
    .fifo_rd_en(rd_en[0]),
    .tx        (tx[0]),
    .busy      (busy[0]),
    .frame_done(done[0])
  );

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(C),
    .PARITY_EN   (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo_empty(empty[1]),
    .fifo_data (fdata[1]),
    .fifo_rd_cs(rd_cs[1]),
    .fifo_rd_en(rd_en[1]),
    .tx        (tx[1]),
    .busy      (busy[1]),
    .frame_done(done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int g,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : mon
    localparam int L = (10 + g) * C;

    logic [8:0]  exp_q [$];
    logic [8:0]  e;
    logic [10:0] frame;
    logic [10:0] ef;
    logic        bitval;
    bit          active   = 0;
    bit          pend     = 0;
    bit          glitch   = 0;
    bit          done_bad = 0;
    bit          busy_bad = 0;
    bit          cs_bad   = 0;
    bit          uf_bad   = 0;
    int          k        = 0;
    int          cyc      = 0;
    int          rd_cyc   = -1000;
    int          end_cyc  = -1000;
    int          last_gap = -1;
    int          rd_cnt   = 0;
    int          rd_ptr   = 0;

    assign empty[g] = (rd_ptr == wr_ptr);

    // FIFO read port: data appears the cycle after the strobe
    always @(posedge clk) begin
      if (pend) begin
        fdata[g] <= mem[rd_ptr % 64];
        rd_ptr   <= rd_ptr + 1;
      end else begin
        fdata[g] <= 8'($urandom);
      end
    end

    always @(negedge clk) begin
      pend = 0;
      if (rst) begin
        if (active) void'(exp_q.pop_front());
        active = 0;
      end else begin
        if (rd_en[g] !== rd_cs[g]) cs_bad = 1;
        if (rd_en[g] === 1'b1) begin
          if (empty[g]) uf_bad = 1;
          pend   = 1;
          rd_cnt++;
          rd_cyc = cyc;
        end
        if (!active) begin
          if (tx[g] === 1'b0) begin
            active   = 1;
            k        = 0;
            frame    = '0;
            last_gap = cyc - end_cyc - 1;
            chk("start_latency", g, cyc - rd_cyc, 2);
          end else if (done[g] !== 1'b0) begin
            done_bad = 1;
          end
        end
        if (active) begin
          if (k % C == 0) bitval = tx[g];
          else if (tx[g] !== bitval) glitch = 1;
          if (k % C == C - 1) frame[k / C] = tx[g];
          if (busy[g] !== 1'b1) busy_bad = 1;
          if (done[g] !== (k == L - 1)) done_bad = 1;
          if (k == L - 1) begin
            chk("exp_avail", g, exp_q.size() != 0, 1);
            e  = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            ef = (g == 1) ? {1'b1, e[8], e[7:0], 1'b0}
                          : {2'b01, e[7:0], 1'b0};
            chk("frame", g, frame, ef);
            chk("bit_hold", g, glitch, 0);
            chk("frame_done", g, done_bad, 0);
            chk("busy_frame", g, busy_bad, 0);
            active  = 0;
            end_cyc = cyc;
          end
          k++;
        end
      end
      cyc++;
    end
  end

  task automatic push(input logic [7:0] b, input logic p);
    mem[wr_ptr % 64] = b;
    wr_ptr++;
    mon[0].exp_q.push_back({p, b});
    mon[1].exp_q.push_back({p, b});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 2'b00 && (empty == 2'b11 || !enable)) && n < 400);
    chk(name, 0, n < 400, 1);
  endtask

  task automatic quiet(input string name);
    bit bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 2'b11 || busy !== 2'b00 || rd_en !== 2'b00) bad = 1;
    end
    chk(name, 0, bad, 0);
  endtask

  initial begin
    int n;
    int rc0;
    int rc1;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 0, tx, 2'b11);
    chk("rst_busy", 0, busy, 2'b00);
    chk("rst_rd_en", 0, rd_en, 2'b00);
    chk("rst_rd_cs", 0, rd_cs, 2'b00);
    chk("rst_done", 0, done, 2'b00);
    rst = 1'b0;

    enable = 1'b1;
    quiet("idle_empty");

    enable = 1'b0;
    push(8'h07, 1'b1);
    quiet("idle_disabled");
    chk("held_byte", 0, empty, 2'b00);
    enable = 1'b1;
    wait_idle("done_07");

    push(8'hA5, 1'b0);
    wait_idle("done_a5");

    enable = 1'b0;
    push(8'h07, 1'b1);
    push(8'hA5, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    wait_idle("done_b2b");
    chk("b2b_gap", 0, mon[0].last_gap, 3);
    chk("b2b_gap", 1, mon[1].last_gap, 3);

    enable = 1'b0;
    push(8'h3C, 1'b0);
    push(8'hC7, 1'b1);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx[0] !== 1'b0 && n < 50);
    chk("start_seen", 0, tx[0], 0);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_tx", 0, tx, 2'b11);
    chk("rst_async_busy", 0, busy, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle("done_after_rst");

    rc0    = mon[0].rd_cnt;
    rc1    = mon[1].rd_cnt;
    enable = 1'b0;
    push(8'h5B, 1'b1);
    push(8'h81, 1'b0);
    enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx[0] !== 1'b0 && n < 50);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    wait_idle("done_drop");
    repeat (20) @(negedge clk);
    chk("drop_reads", 0, mon[0].rd_cnt - rc0, 1);
    chk("drop_reads", 1, mon[1].rd_cnt - rc1, 1);
    chk("drop_left", 0, empty, 2'b00);
    enable = 1'b1;
    wait_idle("done_drain");

    chk("total_reads", 0, mon[0].rd_cnt, 8);
    chk("total_reads", 1, mon[1].rd_cnt, 8);
    chk("sb_empty", 0, mon[0].exp_q.size(), 0);
    chk("sb_empty", 1, mon[1].exp_q.size(), 0);
    chk("cs_eq_en", 0, mon[0].cs_bad, 0);
    chk("cs_eq_en", 1, mon[1].cs_bad, 0);
    chk("underflow", 0, mon[0].uf_bad, 0);
    chk("underflow", 1, mon[1].uf_bad, 0);
    chk("stray_done", 0, mon[0].done_bad, 0);
    chk("stray_done", 1, mon[1].done_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the team's syn_fifo. It pops one byte at a time through the FIFO read port (rd_cs/rd_en, empty, data_out) and serializes each byte as an asynchronous UART frame on a single tx line. Frame format: start bit, DATA_WIDTH data bits LSB first, optional even parity bit, one stop bit. Sits between syn_fifo and the chip pad.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and of the serialized payload
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range >= 2
PARITY_EN, 0, 1 = append an even-parity bit after the data bits; 0 = no parity bit

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  1 = may start new frames; 0 = hold in IDLE after the current frame
fifo_empty  input  1  syn_fifo empty flag
fifo_data  input  DATA_WIDTH  syn_fifo data_out; valid the cycle after a read strobe
fifo_rd_cs  output  1  FIFO read chip select; driven identical to fifo_rd_en
fifo_rd_en  output  1  FIFO read enable; one-cycle pulse per byte
tx  output  1  serial line; idles high
busy  output  1  high whenever state != IDLE
frame_done  output  1  one-cycle pulse in the last cycle of each stop bit

Behaviour:
- Reset, asynchronous: state=IDLE, tx=1, fifo_rd_cs=fifo_rd_en=0, busy=0, frame_done=0, bit and baud counters=0. All outputs are registered.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If enable && !fifo_empty, go to FETCH; otherwise stay in IDLE.
- FETCH: lasts 1 cycle. fifo_rd_cs=fifo_rd_en=1 for exactly this cycle. Go to LOAD.
- LOAD: lasts 1 cycle. Capture fifo_data into the shift register. Compute parity = XOR of the byte. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_WIDTH bits, go to PARITY if PARITY_EN=1, else go to STOP.
- PARITY: tx=parity (even: total count of ones across data and parity is even) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 in its final cycle. Then go to IDLE.
- Timing: first tx falling edge occurs 3 cycles after the IDLE decision cycle (IDLE->FETCH->LOAD->START, registered tx). Frame length is (DATA_WIDTH+2+PARITY_EN)*CLKS_PER_BIT cycles.
- Back-to-back frames: minimum gap between the end of one stop bit and the next start bit is 3 cycles of tx=1 (IDLE, FETCH, LOAD).
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 and resets to 0 on every state change. Bit counter: width $clog2(DATA_WIDTH)+1.
- enable deasserted mid-frame: the current frame completes normally; no new FETCH occurs while enable=0.
- fifo_empty is sampled only in IDLE. A read is never issued while fifo_empty=1, so FIFO underflow is impossible by construction.
- fifo_empty rising during FETCH/LOAD has no effect; the popped byte is sent.
- Reset mid-frame: tx returns to 1 immediately. The byte in flight is lost and is not re-read.

Test Plan:
- CLKS_PER_BIT=4, PARITY_EN=0; push 0x07, enable=1 -> exactly one fifo_rd_en pulse. tx bit sequence 0,1,1,1,0,0,0,0,0,1, each bit held 4 cycles (40 cycles total). frame_done pulses once. busy returns to 0.
- PARITY_EN=1; push 0x07 -> parity bit=1, frame length 44 cycles. Push 0xA5 -> parity bit=0.
- Push 0x07 then 0xA5 back-to-back -> two rd_en pulses. Second start bit begins exactly 3 cycles after the first stop bit ends. Second frame's data bits are 1,0,1,0,0,1,0,1.
- FIFO empty with enable=1 for 100 cycles -> fifo_rd_en never asserts, tx stays 1, busy stays 0. Same with data present but enable=0.
- Assert rst at cycle 10 of a frame -> tx=1 and busy=0 in the same cycle. After release, the next queued byte is sent from its start bit.
- Drop enable during DATA with two bytes queued -> the current frame completes, no further rd_en, one byte remains in the FIFO (empty=0).
